// File: rtl/ddr4_cmd_scheduler_if.sv
// ddr4_cmd_scheduler_if: request stream, status pulses and DDR4 command bus of the scheduler
// Ports (slave = scheduler side):
//   req_valid/req_ready handshake with req_write, req_bg, req_ba, req_row, req_col payload
//   rd_issue/wr_issue one-cycle pulses on RD/WR, ref_miss sticky refresh overrun flag
//   ddr_rstn, ddr_cke, ddr_csb, ddr_actn, ddr_bg, ddr_ba, ddr_addr, ddr_parity DRAM command bus
interface ddr4_cmd_scheduler_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_bg;
    logic [1:0]  req_ba;
    logic [17:0] req_row;
    logic [9:0]  req_col;
    logic        rd_issue;
    logic        wr_issue;
    logic        ref_miss;
    logic        ddr_rstn;
    logic        ddr_cke;
    logic        ddr_csb;
    logic        ddr_actn;
    logic [1:0]  ddr_bg;
    logic [1:0]  ddr_ba;
    logic [17:0] ddr_addr;
    logic        ddr_parity;
    modport master (
        output req_valid, req_write, req_bg, req_ba, req_row, req_col,
        input  req_ready, rd_issue, wr_issue, ref_miss,
        input  ddr_rstn, ddr_cke, ddr_csb, ddr_actn, ddr_bg, ddr_ba, ddr_addr, ddr_parity
    );
    modport slave (
        input  req_valid, req_write, req_bg, req_ba, req_row, req_col,
        output req_ready, rd_issue, wr_issue, ref_miss,
        output ddr_rstn, ddr_cke, ddr_csb, ddr_actn, ddr_bg, ddr_ba, ddr_addr, ddr_parity
    );
endinterface

// File: rtl/ddr4_cmd_scheduler.sv
// ddr4_cmd_scheduler: single-rank DDR4 command sequencer with power-up, row tracking and refresh
// Ports:
//   clk   controller clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   ddr4_cmd_scheduler_if.slave: request handshake, issue pulses, ref_miss, DDR4 command bus
module ddr4_cmd_scheduler #(
    parameter int unsigned T_RST  = 200,
    parameter int unsigned T_CKE  = 500,
    parameter int unsigned T_RP   = 16,
    parameter int unsigned T_RCD  = 16,
    parameter int unsigned T_CCD  = 4,
    parameter int unsigned T_RFC  = 280,
    parameter int unsigned T_REFI = 6240
) (
    input logic                 clk,
    input logic                 rstn,
    ddr4_cmd_scheduler_if.slave bus
);
    typedef enum logic [3:0] {
        INIT_RST, INIT_CKE, IDLE, PRE, WAIT_RP, ACT, WAIT_RCD,
        CAS, WAIT_CCD, PREA, WAIT_RPA, REF, WAIT_RFC
    } state_t;

    localparam logic [15:0] RST_M1  = 16'(T_RST - 1);
    localparam logic [15:0] CKE_M1  = 16'(T_CKE - 1);
    localparam logic [15:0] RP_M1   = 16'(T_RP - 1);
    localparam logic [15:0] RCD_M1  = 16'(T_RCD - 1);
    localparam logic [15:0] CCD_M2  = 16'(T_CCD - 2);
    localparam logic [15:0] RFC_M2  = 16'(T_RFC - 2);
    localparam logic [15:0] REFI_M1 = 16'(T_REFI - 1);

    state_t      st_q, st_d, dec_st;
    logic [15:0] cnt_q, cnt_d, refi_q, refi_d;
    logic        pend_q, pend_d, miss_q, miss_d;
    logic [15:0] open_q, open_d;
    logic [17:0] row_q [16];
    logic        lwr_q, lwr_d;
    logic [3:0]  lbank_q, lbank_d;
    logic [17:0] lrow_q, lrow_d;
    logic [9:0]  lcol_q, lcol_d;
    logic        rstn_q, rstn_d, cke_q, cke_d, csb_q, csb_d, actn_q, actn_d;
    logic [1:0]  bg_q, bg_d, ba_q, ba_d;
    logic [17:0] addr_q, addr_d;
    logic        par_q, par_d, rd_q, rd_d, wr_q, wr_d;
    logic [3:0]  bank;
    logic        dec_pt, pend_eff, ready, hit, running, expire;

    // When T_CCD or T_RFC is 1 the command state itself doubles as the
    // decision cycle so the next command can follow on the very next edge.
    assign dec_pt   = st_q == IDLE || (st_q == CAS && T_CCD == 1) || (st_q == REF && T_RFC == 1);
    // A REF in flight clears the pending flag on this edge.
    assign pend_eff = pend_q && st_q != REF;
    assign ready    = dec_pt && !pend_eff;
    assign bank     = {bus.req_bg, bus.req_ba};
    assign hit      = open_q[bank] && row_q[bank] == bus.req_row;
    assign running  = st_q != INIT_RST && st_q != INIT_CKE;
    assign expire   = running && refi_q == REFI_M1;

    always_comb begin
        dec_st = pend_eff ? ((|open_q) ? PREA : REF) :
                 !bus.req_valid ? IDLE : hit ? CAS : open_q[bank] ? PRE : ACT;
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        open_d  = open_q;
        rstn_d  = rstn_q;
        cke_d   = cke_q;
        csb_d   = 1'b1;
        actn_d  = 1'b1;
        bg_d    = '0;
        ba_d    = '0;
        addr_d  = '0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        lwr_d   = lwr_q;
        lbank_d = lbank_q;
        lrow_d  = lrow_q;
        lcol_d  = lcol_q;
        case (st_q)
            INIT_RST: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == RST_M1) begin
                    rstn_d = 1'b1;
                    cnt_d  = '0;
                    st_d   = INIT_CKE;
                end
            end
            INIT_CKE: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == CKE_M1) begin
                    cke_d = 1'b1;
                    cnt_d = '0;
                    st_d  = IDLE;
                end
            end
            IDLE: st_d = dec_st;
            PRE: begin
                csb_d           = 1'b0;
                {bg_d, ba_d}    = lbank_q;
                addr_d          = 18'h08000;
                open_d[lbank_q] = 1'b0;
                cnt_d           = RP_M1;
                st_d            = (T_RP == 1) ? ACT : WAIT_RP;
            end
            WAIT_RP: begin
                cnt_d = cnt_q - 16'd1;
                st_d  = (cnt_q == 16'd1) ? ACT : WAIT_RP;
            end
            ACT: begin
                csb_d           = 1'b0;
                actn_d          = 1'b0;
                {bg_d, ba_d}    = lbank_q;
                addr_d          = lrow_q;
                open_d[lbank_q] = 1'b1;
                cnt_d           = RCD_M1;
                st_d            = (T_RCD == 1) ? CAS : WAIT_RCD;
            end
            WAIT_RCD: begin
                cnt_d = cnt_q - 16'd1;
                st_d  = (cnt_q == 16'd1) ? CAS : WAIT_RCD;
            end
            CAS: begin
                csb_d        = 1'b0;
                {bg_d, ba_d} = lbank_q;
                // A16..A14 = 101 read / 100 write, A12 = 1 for BL8, A10 = 0 (no auto-precharge)
                addr_d       = {2'b01, 1'b0, !lwr_q, 1'b0, 1'b1, 2'b00, lcol_q};
                rd_d         = !lwr_q;
                wr_d         = lwr_q;
                cnt_d        = CCD_M2;
                st_d         = (T_CCD == 1) ? dec_st : (T_CCD == 2) ? IDLE : WAIT_CCD;
            end
            WAIT_CCD: begin
                cnt_d = cnt_q - 16'd1;
                st_d  = (cnt_q == 16'd1) ? IDLE : WAIT_CCD;
            end
            PREA: begin
                csb_d  = 1'b0;
                addr_d = 18'h08400;
                open_d = '0;
                cnt_d  = RP_M1;
                st_d   = (T_RP == 1) ? REF : WAIT_RPA;
            end
            WAIT_RPA: begin
                cnt_d = cnt_q - 16'd1;
                st_d  = (cnt_q == 16'd1) ? REF : WAIT_RPA;
            end
            REF: begin
                csb_d  = 1'b0;
                addr_d = 18'h04000;
                cnt_d  = RFC_M2;
                st_d   = (T_RFC == 1) ? dec_st : (T_RFC == 2) ? IDLE : WAIT_RFC;
            end
            WAIT_RFC: begin
                cnt_d = cnt_q - 16'd1;
                st_d  = (cnt_q == 16'd1) ? IDLE : WAIT_RFC;
            end
            default: st_d = INIT_RST;
        endcase
        if (ready && bus.req_valid) begin
            lwr_d   = bus.req_write;
            lbank_d = bank;
            lrow_d  = bus.req_row;
            lcol_d  = bus.req_col;
        end
    end

    assign par_d  = ^{actn_d, bg_d, ba_d, addr_d};
    assign refi_d = (!running || expire) ? 16'd0 : refi_q + 16'd1;
    assign pend_d = expire || pend_eff;
    assign miss_d = miss_q || (expire && pend_eff);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q    <= INIT_RST;
            cnt_q   <= '0;
            refi_q  <= '0;
            pend_q  <= 1'b0;
            miss_q  <= 1'b0;
            open_q  <= '0;
            lwr_q   <= 1'b0;
            lbank_q <= '0;
            lrow_q  <= '0;
            lcol_q  <= '0;
            rstn_q  <= 1'b0;
            cke_q   <= 1'b0;
            csb_q   <= 1'b1;
            actn_q  <= 1'b1;
            bg_q    <= '0;
            ba_q    <= '0;
            addr_q  <= '0;
            par_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            refi_q  <= refi_d;
            pend_q  <= pend_d;
            miss_q  <= miss_d;
            open_q  <= open_d;
            lwr_q   <= lwr_d;
            lbank_q <= lbank_d;
            lrow_q  <= lrow_d;
            lcol_q  <= lcol_d;
            rstn_q  <= rstn_d;
            cke_q   <= cke_d;
            csb_q   <= csb_d;
            actn_q  <= actn_d;
            bg_q    <= bg_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            par_q   <= par_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Row contents only matter while the matching open bit is set, so no reset.
    always_ff @(posedge clk) begin
        if (st_q == ACT) row_q[lbank_q] <= lrow_q;
    end

    assign bus.req_ready  = ready;
    assign bus.rd_issue   = rd_q;
    assign bus.wr_issue   = wr_q;
    assign bus.ref_miss   = miss_q;
    assign bus.ddr_rstn   = rstn_q;
    assign bus.ddr_cke    = cke_q;
    assign bus.ddr_csb    = csb_q;
    assign bus.ddr_actn   = actn_q;
    assign bus.ddr_bg     = bg_q;
    assign bus.ddr_ba     = ba_q;
    assign bus.ddr_addr   = addr_q;
    assign bus.ddr_parity = par_q;
endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// tb_ddr4_cmd_scheduler: directed checks of init, page hit/miss, refresh, refresh miss and reset
module tb_ddr4_cmd_scheduler;
    logic clk = 1'b0;
    logic rstn0 = 1'b0;
    logic rstn1 = 1'b0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ddr4_cmd_scheduler_if b0 ();
    ddr4_cmd_scheduler_if b1 ();

    ddr4_cmd_scheduler #(
        .T_RST(4), .T_CKE(6), .T_RP(5), .T_RCD(3), .T_CCD(4), .T_RFC(8), .T_REFI(50)
    ) u0 (.clk(clk), .rstn(rstn0), .bus(b0));

    ddr4_cmd_scheduler #(
        .T_RST(2), .T_CKE(3), .T_RP(16), .T_RCD(1), .T_CCD(1), .T_RFC(20), .T_REFI(10)
    ) u1 (.clk(clk), .rstn(rstn1), .bus(b1));

    logic [23:0] bus0, bus1;
    assign bus0 = {b0.ddr_csb, b0.ddr_actn, b0.ddr_bg, b0.ddr_ba, b0.ddr_addr};
    assign bus1 = {b1.ddr_csb, b1.ddr_actn, b1.ddr_bg, b1.ddr_ba, b1.ddr_addr};

    localparam logic [23:0] DES = 24'hC00000;

    function automatic logic [23:0] cmd(input logic csb, input logic actn, input logic [1:0] bg,
                                        input logic [1:0] ba, input logic [17:0] addr);
        return {csb, actn, bg, ba, addr};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req0(input logic v, input logic w, input logic [1:0] bg, input logic [1:0] ba,
                        input logic [17:0] row, input logic [9:0] col);
        b0.req_valid = v;
        b0.req_write = w;
        b0.req_bg    = bg;
        b0.req_ba    = ba;
        b0.req_row   = row;
        b0.req_col   = col;
    endtask

    task automatic reset_vals0(input string tag);
        chk({tag, "_rstn"}, b0.ddr_rstn, 0);
        chk({tag, "_cke"}, b0.ddr_cke, 0);
        chk({tag, "_bus"}, bus0, DES);
        chk({tag, "_par"}, b0.ddr_parity, 0);
        chk({tag, "_ready"}, b0.req_ready, 0);
        chk({tag, "_issue"}, {b0.rd_issue, b0.wr_issue, b0.ref_miss}, 0);
    endtask

    task automatic init0(input string tag);
        tick(3);
        chk({tag, "_rstn_low3"}, b0.ddr_rstn, 0);
        tick(1);
        chk({tag, "_rstn_high4"}, b0.ddr_rstn, 1);
        chk({tag, "_cke_low4"}, b0.ddr_cke, 0);
        tick(5);
        chk({tag, "_cke_low9"}, b0.ddr_cke, 0);
        chk({tag, "_csb9"}, b0.ddr_csb, 1);
        tick(1);
        chk({tag, "_cke_high10"}, b0.ddr_cke, 1);
        chk({tag, "_ready10"}, b0.req_ready, 1);
        chk({tag, "_bus10"}, bus0, DES);
    endtask

    initial begin
        req0(0, 0, 0, 0, 0, 0);
        b1.req_valid = 0;
        b1.req_write = 0;
        b1.req_bg    = 0;
        b1.req_ba    = 0;
        b1.req_row   = 0;
        b1.req_col   = 0;
        tick(2);
        reset_vals0("reset");
        rstn0 = 1'b1;
        init0("init");
        req0(1, 0, 2'd1, 2'd2, 18'h01234, 10'h008);
        tick(1);
        req0(0, 0, 2'd1, 2'd2, 18'h01234, 10'h008);
        chk("closed_wait", bus0, DES);
        tick(1);
        chk("closed_act", bus0, cmd(0, 0, 1, 2, 18'h01234));
        chk("closed_act_par", b0.ddr_parity, 1);
        tick(2);
        chk("closed_gap", bus0, DES);
        tick(1);
        chk("closed_rd", bus0, cmd(0, 1, 1, 2, 18'h15008));
        chk("closed_rd_par", b0.ddr_parity, 1);
        chk("closed_rd_issue", {b0.rd_issue, b0.wr_issue}, 2'b10);
        tick(1);
        chk("ccd_ready_low", {b0.req_ready, b0.rd_issue}, 0);
        tick(1);
        chk("ccd_ready_high", b0.req_ready, 1);
        req0(1, 1, 2'd1, 2'd2, 18'h01234, 10'h3FF);
        tick(1);
        req0(0, 1, 2'd1, 2'd2, 18'h01234, 10'h3FF);
        chk("hit_wait", bus0, DES);
        tick(1);
        chk("hit_wr", bus0, cmd(0, 1, 1, 2, 18'h113FF));
        chk("hit_wr_par", b0.ddr_parity, 1);
        chk("hit_wr_issue", {b0.rd_issue, b0.wr_issue}, 2'b01);
        tick(2);
        chk("miss_ready", b0.req_ready, 1);
        req0(1, 1, 2'd1, 2'd2, 18'h00055, 10'h010);
        tick(1);
        req0(0, 1, 2'd1, 2'd2, 18'h00055, 10'h010);
        tick(1);
        chk("miss_pre", bus0, cmd(0, 1, 1, 2, 18'h08000));
        chk("miss_pre_par", b0.ddr_parity, 0);
        tick(4);
        chk("miss_rp_gap", bus0, DES);
        tick(1);
        chk("miss_act", bus0, cmd(0, 0, 1, 2, 18'h00055));
        tick(3);
        chk("miss_wr", bus0, cmd(0, 1, 1, 2, 18'h11010));
        chk("miss_wr_issue", b0.wr_issue, 1);
        tick(28);
        chk("refi_before", b0.req_ready, 1);
        tick(1);
        chk("refi_expire_ready", b0.req_ready, 0);
        req0(1, 0, 2'd1, 2'd2, 18'h00055, 10'h020);
        tick(2);
        chk("ref_prea", bus0, cmd(0, 1, 0, 0, 18'h08400));
        tick(5);
        chk("ref_ref", bus0, cmd(0, 1, 0, 0, 18'h04000));
        chk("ref_ref_ready", b0.req_ready, 0);
        tick(5);
        chk("rfc_ready_low", b0.req_ready, 0);
        tick(1);
        chk("rfc_ready_high", b0.req_ready, 1);
        tick(1);
        req0(0, 0, 2'd1, 2'd2, 18'h00055, 10'h020);
        tick(1);
        chk("post_ref_act", bus0, cmd(0, 0, 1, 2, 18'h00055));
        chk("post_ref_nomiss", b0.ref_miss, 0);
        tick(3);
        chk("post_ref_rd", bus0, cmd(0, 1, 1, 2, 18'h15020));
        chk("post_ref_rd_issue", b0.rd_issue, 1);
        tick(2);
        req0(1, 0, 2'd3, 2'd3, 18'h3FFFF, 10'h000);
        tick(1);
        req0(0, 0, 2'd3, 2'd3, 18'h3FFFF, 10'h000);
        tick(1);
        chk("rst_act", bus0, cmd(0, 0, 3, 3, 18'h3FFFF));
        tick(1);
        rstn0 = 1'b0;
        #1;
        reset_vals0("midrst");
        tick(4);
        chk("midrst_no_cas", {b0.ddr_csb, b0.rd_issue, b0.ddr_rstn}, 3'b100);
        rstn0 = 1'b1;
        init0("reinit");
        rstn1 = 1'b1;
        tick(1);
        chk("u1_rstn_low", b1.ddr_rstn, 0);
        tick(1);
        chk("u1_rstn_high", b1.ddr_rstn, 1);
        tick(3);
        chk("u1_cke", {b1.ddr_cke, b1.req_ready}, 2'b11);
        b1.req_valid = 1;
        b1.req_bg    = 2'd0;
        b1.req_ba    = 2'd1;
        b1.req_row   = 18'h00100;
        b1.req_col   = 10'h004;
        tick(1);
        chk("u1_act_ready", b1.req_ready, 0);
        tick(1);
        chk("u1_act", bus1, cmd(0, 0, 0, 1, 18'h00100));
        chk("u1_cas_ready", b1.req_ready, 1);
        tick(1);
        b1.req_valid = 0;
        chk("u1_rd1", bus1, cmd(0, 1, 0, 1, 18'h15004));
        chk("u1_rd1_issue", b1.rd_issue, 1);
        tick(1);
        chk("u1_rd2", bus1, cmd(0, 1, 0, 1, 18'h15004));
        chk("u1_rd2_issue", b1.rd_issue, 1);
        tick(1);
        chk("u1_idle", {bus1, b1.rd_issue}, {DES, 1'b0});
        tick(5);
        chk("u1_exp1_ready", b1.req_ready, 0);
        chk("u1_exp1_nomiss", b1.ref_miss, 0);
        tick(2);
        chk("u1_prea", bus1, cmd(0, 1, 0, 0, 18'h08400));
        tick(7);
        chk("u1_miss_before", b1.ref_miss, 0);
        tick(1);
        chk("u1_miss_set", b1.ref_miss, 1);
        tick(8);
        chk("u1_ref", bus1, cmd(0, 1, 0, 0, 18'h04000));
        tick(20);
        chk("u1_miss_sticky", b1.ref_miss, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ddr4_cmd_scheduler.md
# ddr4_cmd_scheduler

Single-rank DDR4 command scheduler that sequences the x8 DDR4 device command bus (ddr_rstn, ddr_cke, ddr_csb, ddr_actn, ddr_bg, ddr_ba, ddr_addr, ddr_parity) in the memory testbench/controller path. It runs a reduced power-up sequence, tracks open rows for all 16 banks, and converts a valid/ready read/write request stream into PRE/ACT/RD/WR commands with tRP/tRCD/tCCD spacing. It also inserts periodic all-bank refreshes. Mode-register programming and data-path (DQ/DQS) handling are out of scope.

## Interface
- T_RST, 200: cycles ddr_rstn held low after reset release.
- T_CKE, 500: cycles from ddr_rstn high to ddr_cke high.
- T_RP, 16: command-edge spacing PRE/PREA -> next command.
- T_RCD, 16: ACT -> RD/WR spacing.
- T_CCD, 4: RD/WR -> next command spacing.
- T_RFC, 280: REF -> next command spacing.
- T_REFI, 6240: refresh interval in cycles.
- All parameters are 1..65535; counters are 16 bits.

- clk  in  1  controller clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  scheduler accepts request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_bg  in  2  bank group.
- req_ba  in  2  bank.
- req_row  in  18  row address.
- req_col  in  10  column address.
- rd_issue / wr_issue  out  1  one-cycle pulse, coincident with RD/WR on the bus.
- ref_miss  out  1  sticky; set when tREFI expires while a refresh is still pending.
- ddr_rstn, ddr_cke, ddr_csb, ddr_actn  out  1  DRAM control.
- ddr_bg, ddr_ba  out  2  bank group and bank.
- ddr_addr  out  18  A17..A0; A16/A15/A14 carry RAS_n/CAS_n/WE_n when ddr_actn = 1.
- ddr_parity  out  1  even parity over ddr_actn, ddr_bg, ddr_ba, ddr_addr[17:0].

## Operation
- **Reset values:** ddr_rstn = 0, ddr_cke = 0, ddr_csb = 1, ddr_actn = 1, ddr_bg = 0, ddr_ba = 0, ddr_addr = 0, ddr_parity = 0, req_ready = 0, rd_issue = wr_issue = 0, ref_miss = 0. All bank-open bits are cleared.
- **States:** INIT_RST -> INIT_CKE -> IDLE; IDLE -> {PRE, ACT, CAS, PREA, REF}; PRE -> WAIT_RP -> ACT -> WAIT_RCD -> CAS -> WAIT_CCD -> IDLE; PREA -> WAIT_RPA -> REF -> WAIT_RFC -> IDLE.
- **Init:**
  - INIT_RST holds ddr_rstn = 0 for T_RST cycles, then drives ddr_rstn = 1.
  - INIT_CKE waits T_CKE cycles, then drives ddr_cke = 1 and enters IDLE.
  - The tREFI timer starts on entry to IDLE.
- **Accept:** req_ready = 1 only in IDLE with no refresh pending. A transfer occurs when req_valid && req_ready; the request fields are latched on that edge.
- **Bank decision** (by the latched {bg, ba}):
  - Bank open, same row: CAS.
  - Bank closed: ACT.
  - Bank open, different row: PRE.
- **Command encodings** (ddr_csb = 0 for exactly one cycle per command; deselect otherwise with csb = 1, actn = 1, addr = 0):
  - ACT: actn = 0, addr = row.
  - PRE: A16..A14 = 010, A10 = 0.
  - PREA: A16..A14 = 010, A10 = 1.
  - RD: A16..A14 = 101, A12 = 1 (BL8), A10 = 0, A9..A0 = col.
  - WR: A16..A14 = 100, A12 = 1 (BL8), A10 = 0, A9..A0 = col.
  - REF: A16..A14 = 001.
- **Bank-open table:** ACT sets the open bit and row for its bank; PRE clears its bank; PREA clears all banks.
- **Refresh:**
  - The tREFI timer sets ref_pending every T_REFI cycles.
  - In IDLE, a pending refresh has priority over a simultaneously valid request.
  - A request already accepted always completes before the refresh starts.
  - If any bank is open, PREA is issued first; otherwise REF is issued directly.
  - ref_pending clears when REF is issued.
- ddr_parity is computed combinationally from the next-state bus values and registered together with them.

## Timing
- All ddr_* outputs are registered. "Edge k" is the rising edge on which a value appears.
- **Request latency** (request accepted at edge k):
  - Page hit: RD/WR at edge k+1.
  - Bank closed: ACT at k+1, CAS at k+1+T_RCD.
  - Row miss: PRE at k+1, ACT at k+1+T_RP, CAS at k+1+T_RP+T_RCD.
- **Command spacing:**
  - After CAS, req_ready re-asserts at edge CAS+T_CCD-1, so the earliest next command is at CAS+T_CCD.
  - After REF, the earliest next command is at REF+T_RFC.
  - With a parameter = 1, commands issue on consecutive edges.
- rd_issue / wr_issue assert exactly on the CAS edge.
- ref_miss sets at the expiry edge and clears only on reset.
- **Reset mid-operation:** asynchronous return to reset values; any latched request is dropped and the init sequence restarts.

## Test plan
- **Init:** release rstn with T_RST = 4, T_CKE = 6 -> ddr_rstn rises 4 cycles after release, ddr_cke rises 6 cycles later, req_ready = 1 on the next cycle; csb = 1 throughout.
- **Closed-bank read:** bg = 1, ba = 2, row = 0x1234, col = 0x08, T_RCD = 3.
  - ACT with addr = 0x01234 at k+1.
  - RD at k+4 with addr[16:14] = 101, addr[12] = 1, addr[9:0] = 0x008; rd_issue pulses at k+4.
  - ddr_parity correct on both commands.
- **Page hit then row miss:**
  - Write to the same bank/row -> WR one edge after accept, wr_issue pulses.
  - Then row 0x0055 -> PRE (A10 = 0) at k+1, ACT at k+1+T_RP, WR at k+1+T_RP+T_RCD.
- **Refresh preemption:** T_REFI = 50 with one bank open and req_valid held high.
  - At expiry, req_ready = 0.
  - PREA (A10 = 1), then REF T_RP edges later.
  - req_ready = 1 again T_RFC-1 cycles after REF.
  - The next access to the previously open bank issues ACT.
- **Refresh miss:** T_REFI = 10, T_RFC = 20 -> ref_miss sets at the second expiry and stays set.
- **Reset mid-operation:** assert rstn low between ACT and CAS -> all outputs return to reset values immediately, no CAS issues, and the init sequence repeats.
